// File: rtl/add_pkg.sv
// Shared definitions for the exhaustive adder self-test: default width,
// operand range limits and FSM state encoding.
package add_pkg;

  localparam int ADD_WIDTH = 6;

  // Signed range of the default-width adder; the generic versions live in add_self_test.
  localparam logic signed [ADD_WIDTH-1:0] ADD_LOWER = 6'sb100000;
  localparam logic signed [ADD_WIDTH-1:0] ADD_UPPER = 6'sb011111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/add_ref_model.sv
// Golden reference for one operand pair: WIDTH+1-bit signed sum and the
// overflow flag the adder under test should report.
module add_ref_model
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH:0]   exp_sum_o,
  output logic                    exp_ovf_o
);

  // Sign-extended add; the result is out of range exactly when its top two bits differ.
  always_comb begin
    exp_sum_o = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    exp_ovf_o = exp_sum_o[WIDTH] ^ exp_sum_o[WIDTH-1];
  end

endmodule

// File: rtl/add_self_test.sv
// Exhaustive self-test controller: walks every signed operand pair through an
// external adder, checks sum/overflow against add_ref_model and tallies errors.
module add_self_test
  import add_pkg::*;
#(
  parameter int WIDTH         = ADD_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_overflow,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   error_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int                CNT_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [WIDTH-1:0]  LOWER       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  UPPER       = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  OP_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH:0]  ERR_ZERO    = {(2*WIDTH+1){1'b0}};
  localparam logic [2*WIDTH:0]  ERR_ONE     = {{(2*WIDTH){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   err_cnt_q, err_cnt_d;
  logic               fe_valid_q, fe_valid_d;
  logic [WIDTH-1:0]   fe_a_q, fe_a_d, fe_b_q, fe_b_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic signed [WIDTH:0] exp_sum_s;
  logic                  exp_ovf_s;
  logic                  pair_err_s;

  add_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i       (a_q),
    .b_i       (b_q),
    .exp_sum_o (exp_sum_s),
    .exp_ovf_o (exp_ovf_s)
  );

  // Pair verdict; sign-extending the returned sum makes the full compare equal the low-bit compare when no overflow.
  always_comb begin
    pair_err_s = 1'b0;
    if (exp_ovf_s) begin
      pair_err_s = ~dut_overflow;
    end else begin
      pair_err_s = dut_overflow | ({dut_sum[WIDTH-1], dut_sum} != exp_sum_s);
    end
  end

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    fe_valid_d = fe_valid_q;
    fe_a_d     = fe_a_q;
    fe_b_d     = fe_b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          a_d        = LOWER;
          b_d        = LOWER;
          err_cnt_d  = ERR_ZERO;
          fe_valid_d = 1'b0;
          fe_a_d     = {WIDTH{1'b0}};
          fe_b_d     = {WIDTH{1'b0}};
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        if (pair_err_s) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_a_d     = a_q;
            fe_b_d     = b_q;
          end else begin
            fe_valid_d = fe_valid_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (b_q == UPPER) begin
          if (a_q == UPPER) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == ERR_ZERO);
          end else begin
            state_d = ST_DRIVE;
            a_d     = a_q + OP_ONE;
            b_d     = LOWER;
          end
        end else begin
          state_d = ST_DRIVE;
          b_d     = b_q + OP_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      err_cnt_q  <= ERR_ZERO;
      fe_valid_q <= 1'b0;
      fe_a_q     <= {WIDTH{1'b0}};
      fe_b_q     <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      fe_valid_q <= fe_valid_d;
      fe_a_q     <= fe_a_d;
      fe_b_q     <= fe_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign dut_a           = a_q;
  assign dut_b           = b_q;
  assign dut_cin         = 1'b0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_cnt_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;

endmodule

// File: tb/tb_add_self_test.sv
// Bench for add_self_test: a behavioural adder (correct or faulty) drives the
// dut_* ports, and an operand-sweep model predicts the error tally and first failure.
module tb_add_self_test;

  localparam int W          = 6;
  localparam int S          = 2;
  localparam int PAIRS      = 4096;
  localparam int RUN_CYCLES = PAIRS * (S + 2);
  localparam int TIMEOUT    = RUN_CYCLES + 200;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  dut_a, dut_b, dut_sum;
  logic        dut_cin, dut_overflow;
  logic        busy, done, pass;
  logic [12:0] error_count;
  logic        first_err_valid;
  logic [5:0]  first_err_a, first_err_b;

  // Adder fault modes: 0 correct, 1 overflow stuck 0, 2 overflow stuck 1, 3 sum bit 0 flipped on mapped pairs
  int          mode = 0;
  bit          fault_map [0:4095];
  logic [11:0] pair_idx;
  logic [6:0]  adder_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  add_self_test #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dut_a           (dut_a),
    .dut_b           (dut_b),
    .dut_cin         (dut_cin),
    .dut_sum         (dut_sum),
    .dut_overflow    (dut_overflow),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_count     (error_count),
    .first_err_valid (first_err_valid),
    .first_err_a     (first_err_a),
    .first_err_b     (first_err_b)
  );

  function automatic logic [6:0] adder_model(input logic [5:0] a, input logic [5:0] b,
                                             input int md, input bit flt);
    int         s;
    logic [5:0] sum;
    logic       ovf;
    s   = int'($signed(a)) + int'($signed(b));
    sum = 6'(s);
    ovf = (s < -32) || (s > 31);
    if (md == 1) ovf = 1'b0;
    else if (md == 2) ovf = 1'b1;
    else if (md == 3 && flt) sum = sum ^ 6'd1;
    return {ovf, sum};
  endfunction

  assign pair_idx                = {dut_a ^ 6'b100000, dut_b ^ 6'b100000};
  assign adder_out               = adder_model(dut_a, dut_b, mode, fault_map[pair_idx]);
  assign {dut_overflow, dut_sum} = adder_out;

  // Sweep every pair in test order and apply the pass/fail rule to the adder's answers.
  task automatic compute_expected(input int md, output int cnt, output bit fv,
                                  output int fa, output int fb);
    cnt = 0; fv = 1'b0; fa = 0; fb = 0;
    for (int a = -32; a <= 31; a++) begin
      for (int b = -32; b <= 31; b++) begin
        int         s;
        bit         exp_ovf, err;
        logic [6:0] o;
        s       = a + b;
        exp_ovf = (s < -32) || (s > 31);
        o       = adder_model(6'(a), 6'(b), md, fault_map[(a + 32) * 64 + (b + 32)]);
        if (exp_ovf) err = !o[6];
        else         err = o[6] || (o[5:0] != 6'(s));
        if (err) begin
          cnt++;
          if (!fv) begin fv = 1'b1; fa = a; fb = b; end
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // One full run: start, optionally poke start while busy, then check timing and results.
  task automatic run_full(input int md, input bit poke, input string name);
    int cnt, fa, fb, cycles;
    bit fv;
    mode = md;
    compute_expected(md, cnt, fv, fa, fb);
    pulse_start();
    tests_run++;
    if ({busy, done, pass, dut_cin, first_err_valid} !== 5'b10000 || error_count !== 13'd0 ||
        dut_a !== 6'b100000 || dut_b !== 6'b100000) begin
      tests_failed++;
      $display("FAIL %s_start: busy=%b done=%b pass=%b cin=%b fev=%b err=%0d a=%0d b=%0d, required 1 0 0 0 0 0 -32 -32",
               name, busy, done, pass, dut_cin, first_err_valid, error_count, $signed(dut_a), $signed(dut_b));
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
      start = poke && (cycles < RUN_CYCLES - 100) && ($urandom_range(0, 7) == 0);
      if (cycles == 100) begin
        tests_run++;
        if (pass !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s_midrun: busy=%b done=%b pass=%b, required 1 0 0", name, busy, done, pass);
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (cycles !== RUN_CYCLES) begin
      tests_failed++;
      $display("FAIL %s_length: %0d cycles, required %0d", name, cycles, RUN_CYCLES);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (cnt == 0) || error_count !== 13'(cnt)) begin
      tests_failed++;
      $display("FAIL %s_result: done=%b busy=%b pass=%b err=%0d, required 1 0 %b %0d",
               name, done, busy, pass, error_count, (cnt == 0), cnt);
    end
    tests_run++;
    if (first_err_valid !== fv || first_err_a !== (fv ? 6'(fa) : 6'd0) ||
        first_err_b !== (fv ? 6'(fb) : 6'd0)) begin
      tests_failed++;
      $display("FAIL %s_first_err: valid=%b a=%0d b=%0d, required %b %0d %0d",
               name, first_err_valid, $signed(first_err_a), $signed(first_err_b), fv, fa, fb);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, pass, dut_a, dut_b, dut_cin, error_count, first_err_valid, first_err_a, first_err_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: busy=%b done=%b pass=%b a=%h b=%h err=%0d fev=%b, required all 0",
               busy, done, pass, dut_a, dut_b, error_count, first_err_valid);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_correct_adder();
    run_full(0, 1'b0, "correct");
  endtask

  task automatic test_ovf_stuck0();
    run_full(1, 1'b0, "ovf0");
    tests_run++;
    if (error_count !== 13'd1024 || first_err_a !== 6'b100000 || first_err_b !== 6'b100000) begin
      tests_failed++;
      $display("FAIL ovf0_known: err=%0d first=(%0d,%0d), required 1024 (-32,-32)",
               error_count, $signed(first_err_a), $signed(first_err_b));
    end
  endtask

  task automatic test_ovf_stuck1();
    run_full(2, 1'b0, "ovf1");
    tests_run++;
    if (error_count !== 13'd3072 || pass !== 1'b0 || first_err_a !== 6'b100000 || first_err_b !== 6'd0) begin
      tests_failed++;
      $display("FAIL ovf1_known: err=%0d pass=%b first=(%0d,%0d), required 3072 0 (-32,0)",
               error_count, pass, $signed(first_err_a), $signed(first_err_b));
    end
  endtask

  // Abort in the CHECK cycle of a random pair with a = 5 while errors are accumulating.
  task automatic test_reset_mid_run();
    int k;
    mode = 2;
    k = 37 * 64 + int'($urandom_range(0, 63));
    pulse_start();
    repeat (4 * k + 3) @(negedge clk);
    tests_run++;
    if (dut_a !== 6'd5 || busy !== 1'b1 || error_count === 13'd0) begin
      tests_failed++;
      $display("FAIL abort_setup: a=%0d busy=%b err=%0d, required 5 1 nonzero", $signed(dut_a), busy, error_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, pass, dut_a, dut_b, dut_cin, error_count, first_err_valid, first_err_a, first_err_b} !== '0) begin
      tests_failed++;
      $display("FAIL abort_clear: busy=%b done=%b pass=%b a=%h b=%h err=%0d fev=%b, required all 0",
               busy, done, pass, dut_a, dut_b, error_count, first_err_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || error_count !== 13'd0) begin
      tests_failed++;
      $display("FAIL abort_no_resume: busy=%b done=%b err=%0d, required 0 0 0", busy, done, error_count);
    end
  endtask

  task automatic test_back_to_back();
    run_full(0, 1'b1, "rerun_poked");
  endtask

  // Restart from DONE against an adder with random sum faults.
  task automatic test_random_faults();
    int a, b;
    for (int i = 0; i < 24; i++) fault_map[$urandom_range(0, 4095)] = 1'b1;
    a = int'($urandom_range(0, 31)) - 16;
    b = int'($urandom_range(0, 31)) - 16;
    fault_map[(a + 32) * 64 + (b + 32)] = 1'b1;
    run_full(3, 1'b0, "random_faults");
  endtask

  initial begin
    test_reset();
    test_correct_adder();
    test_ovf_stuck0();
    test_ovf_stuck1();
    test_reset_mid_run();
    test_back_to_back();
    test_random_faults();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
